// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D_intf converter among NUM_REQ requesters, with a WAIT watchdog.
// Latency: gnt and strt_cnv 1 cycle after an eligible req; done 1 cycle after cnv_cmplt, or TIMEOUT cycles after WAIT entry.
// Backpressure: req is level-held until done; no new grant while a conversion is in flight.
module a2d_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_chnnl,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [11:0]            result,
    output logic                   err,
    output logic                   busy,
    output logic                   strt_cnv,
    output logic [2:0]             chnnl,
    input  logic                   cnv_cmplt,
    input  logic [11:0]            res
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [PTR_W:0]   NREQ     = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ-1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT-1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, ptr_nxt, win_idx;
    logic [PTR_W:0]     cand;
    logic               win_vld;
    logic [NUM_REQ-1:0] eligible, win_oh;
    logic [TMR_W-1:0]   timer;
    logic [2:0]         chn_arr [NUM_REQ];
    logic               grant, tmr_clr, tmr_inc, cnv_end, cnv_to;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chn
        assign chn_arr[i] = req_chnnl[3*i +: 3];
    end

    // The requester being answered this cycle still holds req; mask it so it cannot win twice in a row.
    assign eligible = req & ~done;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_vld && eligible[cand[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    assign ptr_nxt  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    assign busy     = (state != IDLE);
    assign strt_cnv = (state == START);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        cnv_end   = 1'b0;
        cnv_to    = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant     = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tmr_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion on the last watchdog cycle is still a good conversion.
                if (cnv_cmplt) begin
                    cnv_end   = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TMR_LAST) begin
                    cnv_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= '0;
            done   <= '0;
            err    <= 1'b0;
            chnnl  <= 3'd0;
            result <= 12'd0;
            rr_ptr <= '0;
            timer  <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            if (grant) begin
                gnt    <= win_oh;
                chnnl  <= chn_arr[win_idx];
                rr_ptr <= ptr_nxt;
            end
            if (tmr_clr)      timer <= '0;
            else if (tmr_inc) timer <= timer + 1'b1;
            if (cnv_end) begin
                result <= res;
                done   <= gnt;
                gnt    <= '0;
            end
            if (cnv_to) begin
                result <= 12'd0;
                done   <= gnt;
                err    <= 1'b1;
                gnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter: grant order, channel capture, completion, watchdog and reset recovery.
// Inputs change and outputs are sampled on the falling edge.
module tb_a2d_arbiter;
    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [3*NR-1:0] req_chnnl;
    logic            cnv_cmplt = 1'b0;
    logic [11:0]     res = '0;
    logic [NR-1:0]   gnt, done;
    logic [11:0]     result;
    logic            err, busy, strt_cnv;
    logic [2:0]      chnnl;

    int vec  = 0;
    int miss = 0;
    int ovl  = 0;
    int hot  = 0;
    bit pend = 1'b0;
    int n;
    logic [2:0] chn_tbl [NR];

    a2d_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_chnnl(req_chnnl),
        .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
    );

    always #5 clk = ~clk;

    // Track double start pulses inside one busy period and multi-hot gnt/done.
    always @(negedge clk) begin
        if (!busy) pend = 1'b0;
        if (strt_cnv) begin
            if (pend) ovl++;
            pend = 1'b1;
        end
        if (!$onehot0(gnt) || !$onehot0(done)) hot++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        while (done == '0 && cnt < budget) begin
            step();
            cnt++;
        end
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_gnt"},    gnt,      0);
        chk({tag, "_done"},   done,     0);
        chk({tag, "_err"},    err,      0);
        chk({tag, "_busy"},   busy,     0);
        chk({tag, "_strt"},   strt_cnv, 0);
        chk({tag, "_chnnl"},  chnnl,    0);
        chk({tag, "_result"}, result,   0);
    endtask

    task automatic expect_grant(input string tag, input logic [NR-1:0] g, input logic [2:0] ch);
        chk({tag, "_gnt"},   gnt,      g);
        chk({tag, "_strt"},  strt_cnv, 1);
        chk({tag, "_chnnl"}, chnnl,    ch);
        chk({tag, "_busy"},  busy,     1);
    endtask

    // Called on the strt_cnv cycle; completes lat cycles later, done visible one cycle after that.
    task automatic finish_conv(input int lat, input logic [11:0] r);
        step();
        chk("strt_single", strt_cnv, 0);
        repeat (lat - 1) step();
        cnv_cmplt = 1'b1;
        res       = r;
        step();
        cnv_cmplt = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [NR-1:0] g, input logic [11:0] r, input logic e);
        chk({tag, "_done"},   done,   g);
        chk({tag, "_result"}, result, r);
        chk({tag, "_err"},    err,    e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        chn_tbl   = '{3'd1, 3'd6, 3'd3, 3'd5};
        req_chnnl = {3'd5, 3'd3, 3'd6, 3'd1};
        repeat (3) step();
        chk_rst_vals("rst");
        rst = 1'b0;
        step();

        // Single requester 2 on channel 3.
        req = 4'b0100;
        step();
        expect_grant("t1", 4'b0100, 3'd3);
        finish_conv(12, 12'hA5C);
        check_done("t1", 4'b0100, 12'hA5C, 1'b0);
        req = '0;
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // Watchdog on requester 3; requester 0 granted out of the done cycle.
        req = 4'b1001;
        step();
        expect_grant("to", 4'b1000, 3'd5);
        wait_done(40, n);
        chk("to_latency", n, 17);
        check_done("to", 4'b1000, 12'h000, 1'b1);
        req = 4'b0001;
        step();
        expect_grant("to_next", 4'b0001, 3'd1);
        chk("to_err_pulse", err, 0);

        // Completion on the final watchdog cycle wins.
        finish_conv(TO, 12'h3C7);
        check_done("tie", 4'b0001, 12'h3C7, 1'b0);
        req = '0;
        step();

        // Requester 1 withdraws and changes channel mid-conversion.
        req = 4'b0010;
        step();
        expect_grant("wd", 4'b0010, 3'd6);
        step();
        req = '0;
        req_chnnl[5:3] = 3'd2;
        repeat (3) step();
        chk("wd_chnnl", chnnl, 6);
        chk("wd_busy", busy, 1);
        cnv_cmplt = 1'b1;
        res       = 12'h123;
        step();
        cnv_cmplt = 1'b0;
        check_done("wd", 4'b0010, 12'h123, 1'b0);
        req_chnnl[5:3] = 3'd6;
        step();
        chk("wd_no_regrant", busy, 0);

        // Reset during WAIT, then a stray completion in IDLE.
        req = 4'b0110;
        step();
        expect_grant("rw", 4'b0100, 3'd3);
        repeat (5) step();
        rst = 1'b1;
        step();
        chk_rst_vals("rw");
        rst       = 1'b0;
        req       = '0;
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        step();
        cnv_cmplt = 1'b0;
        chk("stray_done",   done,   0);
        chk("stray_busy",   busy,   0);
        chk("stray_result", result, 0);
        chk("stray_err",    err,    0);
        req = 4'b1110;
        step();
        expect_grant("rw_first", 4'b0010, 3'd6);
        finish_conv(3, 12'h456);
        check_done("rw", 4'b0010, 12'h456, 1'b0);
        req = '0;
        step();

        // All four continuously requesting: strict rotation from index 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        for (int k = 0; k < 6; k++) begin
            logic [NR-1:0] g;
            g = 4'b0001 << (k % NR);
            expect_grant($sformatf("rr%0d", k), g, chn_tbl[k % NR]);
            finish_conv(4 + k, 12'h100 + 12'(k));
            check_done($sformatf("rr%0d", k), g, 12'h100 + 12'(k), 1'b0);
            if (k == 5) req = '0;
            step();
        end
        chk("rr_idle_end", busy, 0);

        chk("strt_overlap", ovl, 0);
        chk("multi_hot", hot, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
